text_overlay_renderer: RTL

- Read-side client of the 8x16 glyph ROM.
- Takes the pixel coordinates and video_on from the VGA sync generator and holds an NCHARS-entry message buffer of 3-bit character codes.
- Drives the glyph ROM address (character, row, column) and turns the returned pixel bit into registered RGB, with hsync/vsync delayed to match.
- Message updates go to a shadow buffer and reach the display only at a frame boundary, so a frame is never torn.

---
 rtl/text_overlay_renderer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/text_overlay_renderer.sv
// Text overlay: maps VGA pixel coordinates onto an NCHARS-character box, drives the glyph ROM
// and registers RGB with matched sync delay. Optional blinking text under macro TEXT_BLINK_EN.
module text_overlay_renderer #(
  parameter logic [9:0] X0       = 10'd288,
  parameter logic [9:0] Y0       = 10'd224,
  parameter int         NCHARS   = 6,
  parameter logic [9:0] V_ACTIVE = 10'd480,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
`ifdef TEXT_BLINK_EN
  ,
  parameter int         BLINK_FRAMES = 30
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       char_wr_en,
  input  logic [2:0] char_wr_idx,
  input  logic [2:0] char_wr_code,
  input  logic       update_req,
  output logic       update_pending,
  output logic       update_done,
  output logic [2:0] character_select,
  output logic [3:0] rom_addr,
  output logic [2:0] rom_col,
  input  logic       rom_bit,
  output logic [7:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic [10:0] X_END    = {1'b0, X0} + 11'(8 * NCHARS);
  localparam logic [10:0] Y_END    = {1'b0, Y0} + 11'd16;
  localparam logic [3:0]  NCHARS_W = 4'(NCHARS);

  logic [2:0] active [0:7];
  logic [2:0] shadow [0:7];

  logic       in_box;
  logic [5:0] dx_low;
  logic [3:0] dy_low;
  logic       boundary;
  logic       show;

  logic       in_box_s1;
  logic [2:0] idx_s1;
  logic [3:0] row_s1;
  logic [2:0] col_s1;
  logic       video_on_s1;
  logic       hsync_s1;
  logic       vsync_s1;

  function automatic logic [2:0] reset_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'd1;
      3'd1:    code = 3'd2;
      3'd2:    code = 3'd3;
      3'd3:    code = 3'd0;
      3'd4:    code = 3'd4;
      3'd5:    code = 3'd5;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Only the low offset bits are ever used, and they do not depend on the upper coordinate bits.
  always_comb begin
    in_box   = ({1'b0, pixel_x} >= {1'b0, X0}) && ({1'b0, pixel_x} < X_END) &&
               ({1'b0, pixel_y} >= {1'b0, Y0}) && ({1'b0, pixel_y} < Y_END);
    dx_low   = pixel_x[5:0] - X0[5:0];
    dy_low   = pixel_y[3:0] - Y0[3:0];
    boundary = (pixel_y == V_ACTIVE) && (pixel_x == 10'd0);
  end

  // Stage 1: box decode and glyph coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_s1   <= 1'b0;
      idx_s1      <= 3'd0;
      row_s1      <= 4'd0;
      col_s1      <= 3'd0;
      video_on_s1 <= 1'b0;
      hsync_s1    <= 1'b1;
      vsync_s1    <= 1'b1;
    end else begin
      in_box_s1   <= in_box;
      video_on_s1 <= video_on;
      hsync_s1    <= hsync_in;
      vsync_s1    <= vsync_in;
      if (in_box) begin
        idx_s1 <= dx_low[5:3];
        row_s1 <= dy_low;
        col_s1 <= ~dx_low[2:0];
      end else begin
        idx_s1 <= 3'd0;
        row_s1 <= 4'd0;
        col_s1 <= 3'd0;
      end
    end
  end

  // Glyph ROM address drive.
  always_comb begin
    if (in_box_s1) begin
      character_select = active[idx_s1];
    end else begin
      character_select = 3'd0;
    end
    rom_addr = row_s1;
    rom_col  = col_s1;
  end

  // Stage 2: colour and sync outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= 8'h00;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hsync_s1;
      vsync_out <= vsync_s1;
      if (!video_on_s1) begin
        rgb <= 8'h00;
      end else if (in_box_s1 && rom_bit && show) begin
        rgb <= FG_COLOR;
      end else begin
        rgb <= BG_COLOR;
      end
    end
  end

  // Shadow buffer writes; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= reset_code(3'(i));
      end
    end else if (char_wr_en && ({1'b0, char_wr_idx} < NCHARS_W)) begin
      shadow[char_wr_idx] <= char_wr_code;
    end
  end

  // Active buffer only changes at a frame boundary, from the pre-edge shadow contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        active[i] <= reset_code(3'(i));
      end
    end else if (update_pending && boundary) begin
      for (int i = 0; i < 8; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  // Update request queueing and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      update_pending <= 1'b0;
      update_done    <= 1'b0;
    end else begin
      update_pending <= update_req | (update_pending & ~boundary);
      update_done    <= update_pending & boundary;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt;

  // Frame counter toggles text visibility every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 6'd0;
      show      <= 1'b1;
    end else if (boundary) begin
      if (frame_cnt == 6'(BLINK_FRAMES - 1)) begin
        frame_cnt <= 6'd0;
        show      <= ~show;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end
`else
  assign show = 1'b1;
`endif

endmodule
